// File: rtl/multu8_seq.sv
// multu8_seq: sequential unsigned 8x8 multiplier.
//
// Computes prod = a * b by eight shift-and-add iterations through one shared
// 10-bit ripple-carry adder. If either operand is zero, the block skips the
// iterations and returns 0 one cycle after accept.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  operand pair a/b presented
//   in_ready  operands accepted (high only while idle)
//   a, b      8-bit unsigned multiplicand / multiplier
//   out_valid prod holds a valid result
//   out_ready consumer takes the result
//   prod      16-bit product
//   busy      an operation is in flight or its result is waiting
module multu8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  mcand;
  logic [9:0]  acc;
  logic [7:0]  q;
  logic [3:0]  cnt;

  logic [9:0]  addend;
  logic [9:0]  sum;

  // Bit-serial carry chain, carry-in 0, result modulo 2^10.
  function automatic logic [9:0] rca10(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] s;
    logic       c;
    c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return s;
  endfunction

  // The shared adder. It adds the multiplicand only when the current
  // multiplier bit is set. Because acc <= 255 and mcand <= 255, sum[9] is always 0.
  always_comb begin
    addend = q[0] ? {2'b00, mcand} : 10'd0;
    sum    = rca10(acc, addend);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      prod      <= 16'd0;
      mcand     <= 8'd0;
      acc       <= 10'd0;
      q         <= 8'd0;
      cnt       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            q        <= b;
            acc      <= 10'd0;
            cnt      <= 4'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (a == 8'd0 || b == 8'd0) begin
              // Zero fast path: the result is known without iterating.
              prod      <= 16'd0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          // The low sum bit shifts into q as the next product bit. The
          // multiplier bit just consumed shifts out of q.
          acc <= {1'b0, sum[9:1]};
          q   <= {sum[0], q[7:1]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            // Load prod from the next-state values {acc_next[7:0], q_next}.
            prod      <= {sum[8:1], sum[0], q[7:1]};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // in_ready stays low here, so no accept can coincide with the
          // result handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multu8_seq.sv
// Directed testbench for multu8_seq.
// Timing reference: inputs are driven and outputs sampled on the falling
// edge. "Edge index" 0 is the falling edge that directly follows the accepting
// rising edge E0. A normal product shows out_valid first at index 8, which is
// after E8. A zero fast-path product shows out_valid first at index 0, which is
// after E0.
module tb_multu8_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] prod;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  multu8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Handshake invariants, checked on every falling edge outside reset.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("inv_ready_not_busy", {31'd0, in_ready}, {31'd0, ~busy});
      chk("inv_valid_implies_busy", {31'd0, out_valid & ~busy}, 32'd0);
    end
  end

  // Start from an idle falling edge. Present the operands for one cycle, then
  // count falling edges until out_valid appears. Bound the wait at 20 edges.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, output int idx);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    in_valid = 1'b0;
    // Later operand changes must have no effect.
    a = 8'(~ta);
    b = 8'(~tb);
    idx = 0;
    while (!out_valid && idx < 20) begin
      @(negedge clk);
      idx++;
    end
  endtask

  // Full transaction with out_ready already high. Check the latency, the
  // product, and the return to idle one cycle later.
  task automatic mult(input logic [7:0] ta, input logic [7:0] tb, input string tag);
    int idx;
    logic [15:0] exp;
    exp = 16'(ta) * 16'(tb);
    out_ready = 1'b1;
    issue(ta, tb, idx);
    chk({tag, "_lat"}, idx, (ta == 0 || tb == 0) ? 0 : 8);
    chk({tag, "_prod"}, {16'd0, prod}, {16'd0, exp});
    @(negedge clk);
    chk({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [7:0] corners [12];

  initial begin
    int idx;
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    logic [15:0] pp [4];

    // Reset state.
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_prod", {16'd0, prod}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Max operands.
    mult(8'd255, 8'd255, "max");
    chk("max_value", {16'd0, 16'(255 * 255)}, 32'hFE01);

    // Zero fast path.
    mult(8'd0, 8'd200, "zero_a");
    mult(8'd37, 8'd0, "zero_b");

    // Backpressure, with ignored in_valid pulses during RUN and DONE.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd13; b = 8'd11;
    @(negedge clk);
    in_valid = 1'b0;
    idx = 0;
    while (!out_valid && idx < 20) begin
      if (idx == 3) begin in_valid = 1'b1; a = 8'd1; b = 8'd1; end
      else in_valid = 1'b0;
      @(negedge clk);
      idx++;
    end
    in_valid = 1'b0;
    chk("bp_lat", idx, 8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_prod_hold", {16'd0, prod}, 32'd143);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_busy_hold", {31'd0, busy}, 32'd1);
      in_valid = (i == 2); a = 8'd1; b = 8'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_prod_final", {16'd0, prod}, 32'd143);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_handshake_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("bp_pulse_not_queued", {31'd0, busy}, 32'd0);

    // Reset mid-run, after the 4th iteration.
    in_valid = 1'b1; a = 8'd200; b = 8'd150;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_prod", {16'd0, prod}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mult(8'd3, 8'd5, "after_rst");

    // Back-to-back, with in_valid and out_ready held high.
    pa[0] = 8'd1;   pb[0] = 8'd1;  pp[0] = 16'd1;
    pa[1] = 8'd128; pb[1] = 8'd2;  pp[1] = 16'd256;
    pa[2] = 8'd255; pb[2] = 8'd1;  pp[2] = 16'd255;
    pa[3] = 8'd170; pb[3] = 8'd85; pp[3] = 16'd14450;
    out_ready = 1'b1;
    in_valid = 1'b1; a = pa[0]; b = pb[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idx = 0;
      while (!out_valid && idx < 20) begin
        @(negedge clk);
        idx++;
      end
      chk("b2b_lat", idx, 8);
      chk("b2b_prod", {16'd0, prod}, {16'd0, pp[k]});
      if (k < 3) begin a = pa[k+1]; b = pb[k+1]; end
      else in_valid = 1'b0;
      @(negedge clk);
      // A new accept happens on the next edge, 10 cycles after the previous one.
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;

    // Corner cross-product plus random pairs, checked against a*b.
    corners[0] = 8'd0;   corners[1] = 8'd1;   corners[2] = 8'd2;
    corners[3] = 8'd3;   corners[4] = 8'd127; corners[5] = 8'd128;
    corners[6] = 8'd129; corners[7] = 8'd170; corners[8] = 8'd85;
    corners[9] = 8'd254; corners[10] = 8'd255; corners[11] = 8'd16;
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 12; j++)
        mult(corners[i], corners[j], "corner");
    for (int r = 0; r < 300; r++)
      mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multu8_seq.md
# multu8_seq

Sequential unsigned 8x8 multiplier that drives one shared 10-bit ripple-carry adder through eight shift-and-add iterations. It produces a 16-bit product with valid/ready handshakes on both the operand and the result side. It sits between the systolic PE operand registers and the accumulation path. It replaces a full combinational array multiplier where area matters more than throughput.

## Interface
Parameters:
- none; the operand width is fixed at 8 and the adder width is fixed at 10.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high; one clock domain.
- in_valid  in  1  the operand pair a and b is presented.
- in_ready  out  1  the block accepts operands; high only in IDLE.
- a  in  8  multiplicand, unsigned.
- b  in  8  multiplier, unsigned.
- out_valid  out  1  the value on prod is the valid result.
- out_ready  in  1  the consumer takes the result.
- prod  out  16  the product a*b.
- busy  out  1  high in RUN and DONE.

## Operation
- Internal registers:
  - mcand[7:0]: latched a.
  - acc[9:0]: upper partial product.
  - q[7:0]: multiplier bits, which shift out as product low bits.
  - cnt[3:0]: iteration count.
  - state: IDLE, RUN or DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch mcand=a, q=b, acc=0, cnt=0.
  - If a==0 or b==0, go to DONE with the prod register set to 0 (zero fast path).
  - Otherwise go to RUN.
- RUN, one iteration per cycle:
  - The shared adder computes sum[9:0] = acc + (q[0] ? {2'b00,mcand} : 10'd0), carry-in 0, modulo 2^10.
  - Update acc <= {1'b0, sum[9:1]}, q <= {sum[0], q[7:1]}, cnt <= cnt+1.
  - The adder never overflows: acc<=255 and mcand<=255, so sum<=510.
- Leaving RUN:
  - The iteration with cnt==7 is the 8th and last.
  - On that edge, load prod <= {sum[8:1], sum[0], q[7:1]} (equal to {acc_next[7:0], q_next}) and go to DONE.
- DONE:
  - out_valid=1 and prod is held stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so a new operand cannot be accepted in the same cycle as the result handshake.
- Input sampling:
  - in_valid while in RUN or DONE is ignored; the operands are not queued.
  - a and b are sampled only on the accept edge; later changes have no effect.
- out_ready outside DONE is ignored.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, prod=0, acc=0, q=0, mcand=0, cnt=0.

## Timing
- Accept edge E0 (in_valid&&in_ready sampled high).
- Normal path:
  - Edges E1..E8 perform iterations 1..8.
  - out_valid rises after E8; latency is 8 cycles from accept to out_valid.
- Zero fast path: out_valid rises after E0 with prod=0; latency is 1 cycle.
- Result handshake:
  - It completes on the first edge where out_valid&&out_ready.
  - in_ready is 1 in the following cycle.
- Best-case throughput: one product per 10 cycles (accept, 8 RUN cycles, DONE with out_ready already high).
- Backpressure: DONE persists indefinitely while out_ready=0; prod, out_valid and busy hold.
- Reset mid-operation:
  - Asserting rst in any state returns the block to reset values immediately (asynchronous).
  - An in-flight product is discarded and no out_valid pulse is produced.
- Deasserting rst: the first accept is possible on the first rising edge after deassertion.
- prod, out_valid, in_ready and busy are decoded from registered state only; there is no combinational path from inputs to outputs.

## Test plan
- Max operands: a=255, b=255, out_ready=1 -> out_valid exactly 8 cycles after accept, prod=16'hFE01 (65025), in_ready high the cycle after the handshake.
- Zero fast path: a=0, b=200 -> out_valid 1 cycle after accept, prod=0; repeat with a=37, b=0 -> prod=0.
- Backpressure: a=13, b=11, out_ready=0 for 5 cycles after out_valid -> prod=143 stable throughout; in_valid pulses with a=1, b=1 during RUN and DONE are ignored; the handshake completes on the cycle out_ready rises.
- Reset mid-run: a=200, b=150; assert rst after the 4th iteration -> out_valid=0, prod=0, in_ready=1 immediately. After release, a=3, b=5 -> prod=15 after 8 cycles.
- Back-to-back: in_valid and out_ready held high with the sequence (1,1), (128,2), (255,1), (170,85) -> prods 1, 256, 255, 14450, each 10 cycles apart.
- Exhaustive: all 65536 (a,b) pairs against the reference a*b. Also check busy==(state!=IDLE) and in_ready==!busy every cycle.
